// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: hazard controller state enum, forward-select encodings, register-0 constant and forward-select helper
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, LONGOP, HALT} state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_we,
    input logic [4:0] mem_dest,
    input logic       wb_we,
    input logic [4:0] wb_dest
  );
    return (mem_we && mem_dest != REG_ZERO && mem_dest == src) ? FWD_EXMEM :
           (wb_we && wb_dest != REG_ZERO && wb_dest == src) ? FWD_MEMWB : FWD_RF;
  endfunction
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: EX operand forwarding selects; in ex_rs/ex_rt and MEM/WB write ports, out fwd_a/fwd_b (00 regfile, 01 EX/MEM, 10 MEM/WB)
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_dest,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_dest,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  assign fwd_a = fwd_sel(ex_rs, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
  assign fwd_b = fwd_sel(ex_rt, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer; in ID/EX/MEM/WB qualifiers, alu_done, resume; out PC/stage enables, flush/bubbles, fwd_a/fwd_b, halted, long_op_err, stall_cnt
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LONG_OP_MAX = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic                   id_halt,
  input  logic                   id_jump,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   ex_valid,
  input  logic                   ex_mem_read,
  input  logic                   ex_reg_write,
  input  logic                   ex_long_op,
  input  logic [4:0]             ex_rs,
  input  logic [4:0]             ex_rt,
  input  logic [4:0]             ex_dest,
  input  logic                   ex_branch_taken,
  input  logic                   alu_done,
  input  logic                   mem_reg_write,
  input  logic                   wb_reg_write,
  input  logic [4:0]             mem_dest,
  input  logic [4:0]             wb_dest,
  input  logic                   resume,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   exmem_bubble,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   halted,
  output logic                   long_op_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam int CW = $clog2(LONG_OP_MAX + 1);
  state_t state;
  logic [CW-1:0] lo_cnt;
  logic [1:0] fa, fb;
  logic load_use, unused_ok;
  assign unused_ok = ex_reg_write;
  fwd_unit u_fwd (
    .ex_rs(ex_rs),
    .ex_rt(ex_rt),
    .mem_reg_write(mem_reg_write),
    .mem_dest(mem_dest),
    .wb_reg_write(wb_reg_write),
    .wb_dest(wb_dest),
    .fwd_a(fa),
    .fwd_b(fb)
  );
  assign fwd_a = rst_n ? fa : FWD_RF;
  assign fwd_b = rst_n ? fb : FWD_RF;
  assign halted = state == HALT;
  assign load_use = ex_valid && ex_mem_read && ex_dest != REG_ZERO && id_valid &&
                    ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
  always_comb begin
    {pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, exmem_bubble} = 6'b111000;
    if (!rst_n)
      {pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, exmem_bubble} = 6'b000111;
    else if (state == HALT)
      {pc_en, ifid_en, ifid_flush, idex_bubble} = {resume, resume, resume, 1'b1};
    else if (state == LONGOP)
      {pc_en, ifid_en, idex_en, exmem_bubble} = alu_done ? 4'b1110 : 4'b0001;
    else if (ex_branch_taken)
      {ifid_flush, idex_bubble} = 2'b11;
    else if (ex_valid && ex_long_op)
      {pc_en, ifid_en, idex_en, exmem_bubble} = 4'b0001;
    else if (load_use || (id_valid && id_halt))
      {pc_en, ifid_en, idex_bubble} = 3'b001;
    else if (id_valid && id_jump)
      ifid_flush = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      lo_cnt <= '0;
      long_op_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!pc_en && state != HALT && !(&stall_cnt)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      case (state)
        RUN: begin
          if (!ex_branch_taken && ex_valid && ex_long_op) begin
            state <= LONGOP;
            lo_cnt <= '0;
          end else if (!ex_branch_taken && !load_use && id_valid && id_halt) state <= HALT;
        end
        LONGOP: begin
          if (alu_done) state <= RUN;
          else if (lo_cnt == CW'(LONG_OP_MAX - 1)) begin
            state <= HALT;
            long_op_err <= 1'b1;
          end else lo_cnt <= lo_cnt + CW'(1);
        end
        HALT: begin
          if (resume) begin
            state <= RUN;
            long_op_err <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
